// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_pkg: shared defaults, FSM states and drain-length helper for the skew feeder
package systolic_pkg;
  localparam int ARRAY_SIZE_DEF = 8;
  localparam int DATA_WIDTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction
endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// skew_lane: DEPTH+1 stage zero-filling delay line; ports clk, reset, en (accept), d, q
module skew_lane #(
  parameter int DEPTH = 0,
  parameter int DATA_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] stage [DEPTH+1];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= en ? d : '0;
      for (int k = 1; k <= DEPTH; k++) stage[k] <= stage[k-1];
    end
  end
  assign q = stage[DEPTH];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews activation/weight beats into a diagonal wavefront, then drains and pulses done; ports: handshake in, skewed vectors/load/busy/done/beat_count out
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_act,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_wt,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] activations,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weights,
  output logic load,
  output logic busy,
  output logic done,
  output logic [CNT_WIDTH-1:0] beat_count
);
  localparam int FW = $clog2(2 * ARRAY_SIZE);
  state_t state, state_n;
  logic [FW-1:0] cnt, cnt_n;
  logic acc;
  assign in_ready = state != DRAIN;
  assign acc = in_valid && in_ready;
  assign busy = state != IDLE;
  // Drain counter is loaded on entry; the cycle whose decrement reaches 0 is the exit cycle.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (acc && in_last) begin
      state_n = DRAIN;
      cnt_n = FW'(flush_len(ARRAY_SIZE));
    end else if (acc && state == IDLE) begin
      state_n = STREAM;
    end else if (state == DRAIN) begin
      cnt_n = cnt - 1'b1;
      state_n = cnt == FW'(1) ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      load <= 1'b0;
      done <= 1'b0;
      beat_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      load <= state_n != IDLE;
      done <= state_n == DRAIN && cnt_n == FW'(1);
      if (acc) beat_count <= state == IDLE ? CNT_WIDTH'(1) : beat_count + CNT_WIDTH'(!(&beat_count));
    end
  end
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    skew_lane #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_act (
      .clk(clk), .reset(reset), .en(acc),
      .d(in_act[i*DATA_WIDTH +: DATA_WIDTH]),
      .q(activations[i*DATA_WIDTH +: DATA_WIDTH])
    );
    skew_lane #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_wt (
      .clk(clk), .reset(reset), .en(acc),
      .d(in_wt[i*DATA_WIDTH +: DATA_WIDTH]),
      .q(weights[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: table-driven check of skew, handshake, drain, reset and saturation
module tb_systolic_skew_feeder;
  localparam int N = 4, DW = 4, W = N * DW;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0;
  logic [W-1:0] in_act = '0, in_wt = '0;
  logic in_ready, load, busy, done;
  logic [W-1:0] activations, weights;
  logic [7:0] beat_count;
  logic r2, l2, b2, d2;
  logic [W-1:0] a2, w2;
  logic [1:0] bc2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_act(in_act), .in_wt(in_wt), .activations(activations), .weights(weights),
    .load(load), .busy(busy), .done(done), .beat_count(beat_count));
  systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r2), .in_last(in_last),
    .in_act(in_act), .in_wt(in_wt), .activations(a2), .weights(w2),
    .load(l2), .busy(b2), .done(d2), .beat_count(bc2));
  typedef struct {
    logic v, l;
    logic [W-1:0] act, wt;
    logic rdy, ld, bsy, dn;
    logic [W-1:0] ea, ew;
    logic [7:0] bc;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic v, l, input logic [W-1:0] act, wt,
                              input logic rdy, ld, bsy, dn, input logic [W-1:0] ea, ew,
                              input logic [7:0] bc);
    vec_t t;
    t.v = v; t.l = l; t.act = act; t.wt = wt;
    t.rdy = rdy; t.ld = ld; t.bsy = bsy; t.dn = dn;
    t.ea = ea; t.ew = ew; t.bc = bc;
    return t;
  endfunction
  task automatic chk(input string name, input int idx, input logic [W-1:0] got, exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // single beat, lanes act {1,2,3,4}, wt {5,6,7,-8}
    tbl.push_back(mk(1, 1, 16'h4321, 16'h8765, 1, 0, 0, 0, 16'h0000, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0001, 16'h0005, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0020, 16'h0060, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0300, 16'h0700, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h4000, 16'h8000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1));
    // four back-to-back beats, act b on all lanes, wt b+4
    tbl.push_back(mk(1, 0, 16'h1111, 16'h5555, 1, 0, 0, 0, 16'h0000, 16'h0000, 1));
    tbl.push_back(mk(1, 0, 16'h2222, 16'h6666, 1, 1, 1, 0, 16'h0001, 16'h0005, 1));
    tbl.push_back(mk(1, 0, 16'h3333, 16'h7777, 1, 1, 1, 0, 16'h0012, 16'h0056, 2));
    tbl.push_back(mk(1, 1, 16'h4444, 16'h8888, 1, 1, 1, 0, 16'h0123, 16'h0567, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h1234, 16'h5678, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h2340, 16'h6780, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h3400, 16'h7800, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h4000, 16'h8000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 4));
    // bubble: beat, gap, last beat
    tbl.push_back(mk(1, 0, 16'h1111, 16'h2222, 1, 0, 0, 0, 16'h0000, 16'h0000, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 16'h0001, 16'h0002, 1));
    tbl.push_back(mk(1, 1, 16'h3333, 16'h4444, 1, 1, 1, 0, 16'h0010, 16'h0020, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0103, 16'h0204, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h1030, 16'h2040, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0300, 16'h0400, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h3000, 16'h4000, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 16'h0000, 16'h0000, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 2));
    tick;
    tick;
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      chk("idle_ready", i, in_ready, 1);
      chk("idle_busy", i, busy, 0);
      chk("idle_load", i, load, 0);
      chk("idle_done", i, done, 0);
      chk("idle_act", i, activations, 0);
      chk("idle_wt", i, weights, 0);
      chk("idle_count", i, beat_count, 0);
      tick;
    end
    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_last = tbl[i].l;
      in_act = tbl[i].act;
      in_wt = tbl[i].wt;
      chk("ready", i, in_ready, tbl[i].rdy);
      chk("load", i, load, tbl[i].ld);
      chk("busy", i, busy, tbl[i].bsy);
      chk("done", i, done, tbl[i].dn);
      chk("act", i, activations, tbl[i].ea);
      chk("wt", i, weights, tbl[i].ew);
      chk("count", i, beat_count, tbl[i].bc);
      tick;
    end
    // reset two cycles into drain discards everything
    in_valid = 1; in_last = 1; in_act = 16'h5555; in_wt = 16'h6666;
    tick;
    in_valid = 0; in_last = 0; in_act = '0; in_wt = '0;
    chk("rst_drain_ready", 0, in_ready, 0);
    tick;
    reset = 1;
    tick;
    reset = 0;
    chk("rst_ready", 0, in_ready, 1);
    chk("rst_busy", 0, busy, 0);
    chk("rst_load", 0, load, 0);
    chk("rst_count", 0, beat_count, 0);
    for (int i = 0; i < 12; i++) begin
      chk("rst_no_done", i, done, 0);
      chk("rst_act", i, activations, 0);
      chk("rst_wt", i, weights, 0);
      tick;
    end
    // saturation of a 2-bit beat counter over five beats
    for (int b = 0; b < 5; b++) begin
      in_valid = 1;
      in_last = b == 4;
      in_act = 16'h1111 * (b + 1);
      in_wt = 16'h1111 * (b + 1);
      if (b >= 3) begin
        chk("sat_count8", b, beat_count, b);
        chk("sat_count2", b, bc2, 3);
      end
      tick;
    end
    in_valid = 0; in_last = 0; in_act = '0; in_wt = '0;
    chk("sat_count8", 5, beat_count, 5);
    chk("sat_count2", 5, bc2, 3);
    begin
      int n = 0;
      while (!done && n < 20) begin
        tick;
        n++;
      end
    end
    chk("sat_done_seen", 0, done, 1);
    chk("sat_done_cycles", 0, busy, 1);
    tick;
    chk("sat_idle_busy", 0, busy, 0);
    chk("sat_hold2", 0, bc2, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage of the systolic matrix-multiply array.
- Accepts one activation vector and one weight vector per beat over a valid/ready handshake.
- Lane i of each vector is delayed by i cycles, producing the diagonal wavefront the array needs, and the block drives the array's `activations`, `weights` and `load` inputs.
- After the final beat it flushes zeros until the wavefront has cleared the array, then pulses `done`.

Parameters:
- ARRAY_SIZE, 8, number of lanes; equals the array's rows and columns.
- DATA_WIDTH, 4, signed element width, matching the array.
- CNT_WIDTH, 8, width of the accepted-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- in_last  in  1  marks the final beat of a matrix; qualified by in_valid && in_ready.
- in_act  in  ARRAY_SIZE*DATA_WIDTH  signed activation vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_wt  in  ARRAY_SIZE*DATA_WIDTH  signed weight vector, same lane packing.
- activations  out  ARRAY_SIZE*DATA_WIDTH  skewed activations to the array.
- weights  out  ARRAY_SIZE*DATA_WIDTH  skewed weights to the array.
- load  out  1  array load/enable.
- busy  out  1  high in STREAM or DRAIN.
- done  out  1  one-cycle pulse at the end of the drain.
- beat_count  out  CNT_WIDTH  number of beats accepted for the current matrix.

Behaviour:
- Reset values:
  - state = IDLE; all delay stages = 0.
  - activations = weights = 0.
  - load = busy = done = 0; beat_count = 0.
  - in_ready = 1 (in_ready is combinational from state).
- Handshake:
  - Beat accepted on (in_valid && in_ready) at a rising edge.
  - in_ready = 1 in IDLE and STREAM, 0 in DRAIN.
- Skew:
  - An accepted beat enters every lane's delay line in the accept cycle.
  - Lane i element appears on activations/weights exactly 1+i cycles after the accept edge. Lane 0 latency is 1; lane ARRAY_SIZE-1 latency is ARRAY_SIZE.
  - Any cycle without an accepted beat (bubble, DRAIN, IDLE) injects zeros into all lanes. Bubbles therefore propagate as zero diagonals.
  - Activation and weight lanes use identical delays.
- FSM:
  - IDLE:
    - accept with in_last=0 -> STREAM.
    - accept with in_last=1 -> DRAIN.
    - no accept -> stay.
  - STREAM:
    - accept with in_last=1 -> DRAIN.
    - otherwise stay; bubbles are allowed.
  - DRAIN:
    - A flush counter loads 2*ARRAY_SIZE-1 on entry and decrements each cycle.
    - At 0 -> IDLE, with done=1 for exactly that transition cycle.
- load: registered, equal to (next_state != IDLE) delayed one cycle, so it aligns with lane-0 data. Deasserts the cycle after done.
- busy: high when state is STREAM or DRAIN.
- beat_count:
  - Cleared on the accept that leaves IDLE, then counts that beat as 1.
  - Increments on each later accept.
  - Holds through DRAIN and IDLE until the next matrix starts.
  - Saturates at all-ones; no wrap.
- Simultaneous events: reset has priority over everything. An accept in the same cycle as the DRAIN counter reaching 0 is impossible, because in_ready=0 in DRAIN.
- Reset mid-operation: the next cycle is IDLE, all outputs are zero, and in-flight data is discarded with no done pulse.
- Widths: data passes through unmodified; signedness is preserved and no arithmetic is applied.

Decomposition:
- Package systolic_pkg holds:
  - default ARRAY_SIZE and DATA_WIDTH;
  - the FSM state enum (IDLE, STREAM, DRAIN);
  - the function flush_len(n) = 2*n-1.
- Sub-module skew_lane #(DEPTH, DATA_WIDTH):
  - a synchronous-reset delay line with DEPTH+1 registers, input zeroed when not accepting;
  - instantiated 2*ARRAY_SIZE times via generate.

Test Plan (ARRAY_SIZE=4, DATA_WIDTH=4 override):
- Reset, then idle -> in_ready=1, busy=0, all outputs 0 for 10 cycles.
- Single beat: in_act lanes {1,2,3,4}, in_wt lanes {5,6,7,-8}, in_last=1 -> act lane0=1 at cycle+1, lane1=2 at +2, lane2=3 at +3, lane3=4 at +4; weights likewise with -8 on lane3 at +4; done pulses 7 cycles after accept; beat_count=1.
- Four back-to-back beats with act lane values 1,2,3,4 on every lane, last on beat 4 -> lane3 shows 1,2,3,4 at cycles +4..+7; in_ready drops the cycle after beat 4; beat_count=4; done 7 cycles after the last accept.
- Bubble: beats 1, gap, 2 -> a zero diagonal separates them on every lane; beat_count=2.
- Reset asserted two cycles into DRAIN -> next cycle IDLE, outputs 0, no done pulse, in_ready=1.
- Saturation with CNT_WIDTH=2: five beats -> beat_count stays 3.
